instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Initiator-side partner of the processor control FSM (run/Done handshake, 9-bit instruction word on DIN).
- Holds a small writable program memory and feeds it to the processor one instruction at a time.
- Issues `run` for each instruction, presents the immediate word on `din` for mvi (opcode 3'b001), and waits for `done` before issuing the next word.
- Adds a timeout watchdog and structural error checks; used by the CPU top level and the system bench in place of manual switch input.

Parameters:
- AW, 4: program address width; memory depth = 2**AW words of 9 bits.
- TIMEOUT, 16: maximum cycles spent in WAIT without `done` before a timeout error is flagged.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- prog_we  in  1  program write strobe; ignored while busy.
- prog_addr  in  AW  program write address.
- prog_wdata  in  9  program write data.
- prog_len  in  AW+1  number of words to execute, 0..2**AW; sampled on start.
- start  in  1  begin execution at address 0; ignored while busy.
- done  in  1  processor Done; high whenever the processor FSM is idle.
- run  out  1  one-cycle instruction request to the processor.
- din  out  9  processor DIN bus.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- finished  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag; cleared by the next accepted start.
- err_code  out  2  00 none, 01 timeout, 10 truncated mvi, 11 prog_len > 2**AW.
- pc  out  AW+1  address of the current word.
- instr_count  out  8  instructions completed since start; wraps at 255 -> 0; mvi counts as 1.

Behaviour:
- Reset (resetn=0 at posedge): all outputs 0; state IDLE; memory contents unchanged.
- Memory: write-only port; a write occurs at posedge when prog_we=1 and state=IDLE. Read is combinational, internal only.
- Reset mid-operation: abort immediately. No further `run`; `din`=0 the following cycle.

State machine:
- IDLE: run=0, din=0, busy=0.
  - start & prog_len==0 -> finished pulse, stay IDLE.
  - start & prog_len>2**AW -> error=1, err_code=11, no run issued.
  - Otherwise -> clear error/err_code/instr_count, pc=0, go to FETCH.
- FETCH (1 cycle): latch ir=mem[pc]; if ir[8:6]==001, latch imm=mem[pc+1].
  - If ir[8:6]==001 and pc+1>=prog_len -> error, err_code=10, go to IDLE. No run issued.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle): run=1, din=ir -> HOLD.
- HOLD (1 cycle; processor latches IR): run=0, din=ir -> DEC.
- DEC: din=imm if mvi else ir; clear the timeout counter -> WAIT.
- WAIT: hold din.
  - done=1 -> instr_count+1; pc += 2 (mvi) or 1.
  - Then if new pc >= prog_len -> IDLE with finished=1, else -> FETCH.
  - If done is still 0 after TIMEOUT cycles -> error, err_code=01, go to IDLE.
- `done` is sampled only in WAIT. Its idle-high level in every other state is ignored.
- Timing:
  - `din` must equal the instruction during the processor IR-load cycle (ISSUE+1).
  - `din` must equal the immediate by processor state s4 (ISSUE+3).
  - Processor Done rises no earlier than ISSUE+4, so WAIT always observes a real completion.
- Issue-to-issue period: 6 cycles for mv/mvi, 8 cycles for 3-step ops (add/sub).
- Simultaneous events:
  - start with prog_we in IDLE: the write completes and execution starts; the written word is visible to FETCH.
  - done and timeout expiry in the same cycle: done wins.

Test Plan:
- Reset: resetn=0 for 2 cycles, then 1 -> run=0, din=0, busy=0, error=0, pc=0, instr_count=0.
- Program 0x040,0x005,0x008; prog_len=3; start; processor model completes each instruction -> run pulses twice.
  - din=0x040 through HOLD, then 0x005 during WAIT; then din=0x008.
  - finished pulse; instr_count=2; pc=3.
- Program 0x081 (add), prog_len=1 -> Done returns at ISSUE+6; next state IDLE; finished 1 cycle; run asserted exactly once.
- Program 0x040 only, prog_len=1 -> no run ever; error=1, err_code=10, busy drops after FETCH.
- Processor model holds done=0 forever, TIMEOUT=16 -> error=1, err_code=01 exactly 16 cycles after entering WAIT; run=0 thereafter.
- Mid-run robustness:
  - start and prog_we pulsed while busy -> both ignored; memory word unchanged.
  - resetn=0 during WAIT -> next cycle run=0, din=0, busy=0.
  - prog_len=17 with AW=4 -> err_code=11.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// program-load port, start/status signals and the processor run/done/DIN link.
interface instr_sequencer_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [8:0]    prog_wdata;
  logic [AW:0]   prog_len;
  logic          start;
  logic          done;
  logic          run;
  logic [8:0]    din;
  logic          busy;
  logic          finished;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   pc;
  logic [7:0]    instr_count;

  // Sequencer side: drives the processor request and status outputs.
  modport master (
    input  prog_we, prog_addr, prog_wdata, prog_len, start, done,
    output run, din, busy, finished, error, err_code, pc, instr_count
  );

  // Environment side: loads the program, starts it and answers with done.
  modport slave (
    output prog_we, prog_addr, prog_wdata, prog_len, start, done,
    input  run, din, busy, finished, error, err_code, pc, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program memory and feeds it word by
// word to the processor control FSM using the run/done handshake. mvi words
// are followed by their immediate, which is presented on din after the
// processor has loaded the instruction. A watchdog bounds the wait for done.
module instr_sequencer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  instr_sequencer_if.master bus
);
  localparam int          DEPTH   = 2**AW;
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [2:0]  OP_MVI  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_DEC, S_WAIT
  } state_t;

  state_t        r_state;
  logic [8:0]    r_mem [DEPTH];
  logic [8:0]    r_ir;
  logic [8:0]    r_imm;
  logic [AW:0]   r_len;
  logic [AW:0]   r_pc;
  logic [TW-1:0] r_tmo;
  logic          r_run;
  logic [8:0]    r_din;
  logic          r_busy;
  logic          r_finished;
  logic          r_error;
  logic [1:0]    r_err_code;
  logic [7:0]    r_count;

  logic [AW:0]   w_pc_p1;
  logic [AW:0]   w_pc_next;
  logic [8:0]    w_word;
  logic [8:0]    w_word_p1;
  logic          w_word_mvi;
  logic          w_ir_mvi;

  // The immediate address may run past the memory when pc is the last word;
  // that case is always rejected as a truncated mvi, so truncation is safe.
  assign w_pc_p1    = r_pc + (AW+1)'(1);
  assign w_pc_next  = w_ir_mvi ? r_pc + (AW+1)'(2) : w_pc_p1;
  assign w_word     = r_mem[r_pc[AW-1:0]];
  assign w_word_p1  = r_mem[w_pc_p1[AW-1:0]];
  assign w_word_mvi = (w_word[8:6] == OP_MVI);
  assign w_ir_mvi   = (r_ir[8:6] == OP_MVI);

  // Program memory write port: open only while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && r_state == S_IDLE) begin
      r_mem[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  // Instruction and immediate latches, loaded during FETCH.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH) begin
      r_ir <= w_word;
      if (w_word_mvi) begin
        r_imm <= w_word_p1;
      end
    end
  end

  // Sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_din      <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_pc       <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_tmo      <= '0;
    end else begin
      r_run      <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.prog_len == '0) begin
              r_finished <= 1'b1;
            end else if (bus.prog_len > LEN_MAX) begin
              r_error    <= 1'b1;
              r_err_code <= 2'b11;
            end else begin
              r_error    <= 1'b0;
              r_err_code <= 2'b00;
              r_count    <= '0;
              r_pc       <= '0;
              r_len      <= bus.prog_len;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_word_mvi && w_pc_p1 >= r_len) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b10;
            r_busy     <= 1'b0;
            r_din      <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_run   <= 1'b1;
            r_din   <= w_word;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_HOLD;
        S_HOLD: begin
          // Processor has latched IR by now; switch din to the immediate.
          r_din   <= w_ir_mvi ? r_imm : r_ir;
          r_state <= S_DEC;
        end
        S_DEC: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins over a same-cycle timeout.
          if (bus.done) begin
            r_count <= r_count + 8'd1;
            r_pc    <= w_pc_next;
            if (w_pc_next >= r_len) begin
              r_finished <= 1'b1;
              r_busy     <= 1'b0;
              r_din      <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
            end
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b01;
            r_busy     <= 1'b0;
            r_din      <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.run         = r_run;
  assign bus.din         = r_din;
  assign bus.busy        = r_busy;
  assign bus.finished    = r_finished;
  assign bus.error       = r_error;
  assign bus.err_code    = r_err_code;
  assign bus.pc          = r_pc;
  assign bus.instr_count = r_count;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program runs against a small processor
// model that consumes run pulses, checks din timing against a queue of
// expected words and answers with done after the opcode's latency.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int AW      = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [8:0] ir;
    logic [8:0] imm;
    logic       mvi;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW)) bus ();
  instr_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   run_cnt    = 0;
  int   last_issue = 0;
  int   prog_id    = 0;
  bit   hang       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.run === 1'b1) run_cnt <= run_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [8:0] d);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = a;
    bus.prog_wdata = d;
    @(negedge clk);
    bus.prog_we    = 1'b0;
  endtask

  task automatic start_prog(input logic [AW:0] len);
    prog_id++;
    bus.prog_len = len;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.finished === 1'b1 || bus.error === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("end_within_budget", 32'(at >= 0), 32'd1);
  endtask

  // Processor model: done drops after run is taken and rises ISSUE+4
  // (mv/mvi) or ISSUE+6 (other ops); in hang mode it stays low.
  initial begin : proc_model
    exp_t e;
    int   lat;
    int   t0;
    int   prev_issue;
    int   prev_gap;
    int   prev_id;
    bus.done   = 1'b1;
    prev_id    = -1;
    prev_issue = 0;
    prev_gap   = 0;
    forever begin
      @(negedge clk);
      if (bus.run === 1'b1) begin
        t0         = cyc;
        last_issue = t0;
        if (prev_id == prog_id) chk("issue_period", 32'(t0 - prev_issue), 32'(prev_gap));
        lat        = (bus.din[8:7] == 2'b00) ? 4 : 6;
        prev_id    = prog_id;
        prev_issue = t0;
        prev_gap   = lat + 2;
        chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{ir: 9'h0, imm: 9'h0, mvi: 1'b0};
        @(negedge clk);
        bus.done = 1'b0;
        chk("run_one_cycle", 32'(bus.run), 32'd0);
        chk("din_ir_at_load", 32'(bus.din), 32'(e.ir));
        repeat (2) @(negedge clk);
        if (e.mvi) chk("din_imm_at_s4", 32'(bus.din), 32'(e.imm));
        if (hang) begin
          while (hang) @(negedge clk);
        end else begin
          repeat (lat - 3) @(negedge clk);
        end
        bus.done = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int at;
    int base;
    resetn         = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.prog_len   = '0;
    bus.start      = 1'b0;
    tick(2);
    chk("rst_run",   32'(bus.run), 32'd0);
    chk("rst_din",   32'(bus.din), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_code",  32'(bus.err_code), 32'd0);
    chk("rst_pc",    32'(bus.pc), 32'd0);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    chk("rst_fin",   32'(bus.finished), 32'd0);
    resetn = 1'b1;
    tick();

    // prog_len beyond the memory depth
    base = run_cnt;
    start_prog(5'd17);
    chk("len17_error", 32'(bus.error), 32'd1);
    chk("len17_code",  32'(bus.err_code), 32'd3);
    chk("len17_busy",  32'(bus.busy), 32'd0);
    tick(3);
    chk("len17_no_run", 32'(run_cnt - base), 32'd0);

    // empty program
    start_prog(5'd0);
    chk("len0_fin",  32'(bus.finished), 32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("len0_fin_pulse", 32'(bus.finished), 32'd0);

    // mvi + mv program
    write_word(4'd0, 9'h040);
    write_word(4'd1, 9'h005);
    write_word(4'd2, 9'h008);
    exp_q.push_back('{ir: 9'h040, imm: 9'h005, mvi: 1'b1});
    exp_q.push_back('{ir: 9'h008, imm: 9'h000, mvi: 1'b0});
    base = run_cnt;
    start_prog(5'd3);
    chk("p1_busy",        32'(bus.busy), 32'd1);
    chk("p1_err_cleared", 32'(bus.error), 32'd0);
    wait_end(80, at);
    chk("p1_fin",      32'(bus.finished), 32'd1);
    chk("p1_fin_time", 32'(at), 32'(last_issue + 5));
    chk("p1_count",    32'(bus.instr_count), 32'd2);
    chk("p1_pc",       32'(bus.pc), 32'd3);
    chk("p1_busy_end", 32'(bus.busy), 32'd0);
    chk("p1_din_end",  32'(bus.din), 32'd0);
    tick(2);
    chk("p1_runs",      32'(run_cnt - base), 32'd2);
    chk("p1_fin_pulse", 32'(bus.finished), 32'd0);
    chk("p1_q_empty",   32'(exp_q.size()), 32'd0);

    // single 3-step op
    write_word(4'd0, 9'h081);
    exp_q.push_back('{ir: 9'h081, imm: 9'h000, mvi: 1'b0});
    base = run_cnt;
    start_prog(5'd1);
    wait_end(80, at);
    chk("add_fin",      32'(bus.finished), 32'd1);
    chk("add_fin_time", 32'(at), 32'(last_issue + 7));
    chk("add_count",    32'(bus.instr_count), 32'd1);
    chk("add_pc",       32'(bus.pc), 32'd1);
    tick(2);
    chk("add_runs", 32'(run_cnt - base), 32'd1);

    // truncated mvi
    write_word(4'd0, 9'h040);
    base = run_cnt;
    start_prog(5'd1);
    chk("trunc_busy_fetch", 32'(bus.busy), 32'd1);
    tick();
    chk("trunc_busy", 32'(bus.busy), 32'd0);
    chk("trunc_err",  32'(bus.error), 32'd1);
    chk("trunc_code", 32'(bus.err_code), 32'd2);
    chk("trunc_din",  32'(bus.din), 32'd0);
    tick(3);
    chk("trunc_no_run", 32'(run_cnt - base), 32'd0);

    // watchdog timeout
    write_word(4'd0, 9'h000);
    exp_q.push_back('{ir: 9'h000, imm: 9'h000, mvi: 1'b0});
    hang = 1'b1;
    base = run_cnt;
    start_prog(5'd1);
    wait_end(60, at);
    chk("tmo_err",  32'(bus.error), 32'd1);
    chk("tmo_code", 32'(bus.err_code), 32'd1);
    chk("tmo_time", 32'(at), 32'(last_issue + 3 + TIMEOUT));
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    tick(4);
    chk("tmo_runs", 32'(run_cnt - base), 32'd1);
    chk("tmo_run0", 32'(bus.run), 32'd0);
    hang = 1'b0;
    tick(2);

    // start/prog_we while busy, then reset during WAIT
    write_word(4'd0, 9'h012);
    exp_q.push_back('{ir: 9'h012, imm: 9'h000, mvi: 1'b0});
    hang = 1'b1;
    base = run_cnt;
    start_prog(5'd1);
    tick(5);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 4'd0;
    bus.prog_wdata = 9'h1FF;
    bus.start      = 1'b1;
    tick();
    bus.prog_we    = 1'b0;
    bus.start      = 1'b0;
    tick(3);
    chk("busy_ign_runs", 32'(run_cnt - base), 32'd1);
    chk("busy_ign_busy", 32'(bus.busy), 32'd1);
    chk("busy_ign_err",  32'(bus.error), 32'd0);
    resetn = 1'b0;
    tick();
    chk("midrst_run",  32'(bus.run), 32'd0);
    chk("midrst_din",  32'(bus.din), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_pc",   32'(bus.pc), 32'd0);
    resetn = 1'b1;
    hang   = 1'b0;
    tick(2);
    exp_q.push_back('{ir: 9'h012, imm: 9'h000, mvi: 1'b0});
    base = run_cnt;
    start_prog(5'd1);
    wait_end(80, at);
    chk("mem_kept_fin", 32'(bus.finished), 32'd1);
    tick(2);
    chk("mem_kept_runs", 32'(run_cnt - base), 32'd1);
    chk("mem_kept_q",    32'(exp_q.size()), 32'd0);

    // write and start in the same idle cycle
    exp_q.push_back('{ir: 9'h00A, imm: 9'h000, mvi: 1'b0});
    base = run_cnt;
    prog_id++;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 4'd0;
    bus.prog_wdata = 9'h00A;
    bus.prog_len   = 5'd1;
    bus.start      = 1'b1;
    tick();
    bus.prog_we    = 1'b0;
    bus.start      = 1'b0;
    wait_end(80, at);
    chk("wr_start_fin", 32'(bus.finished), 32'd1);
    tick(2);
    chk("wr_start_runs", 32'(run_cnt - base), 32'd1);
    chk("wr_start_q",    32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
